// File: rtl/image_invert_engine_if.sv
// rtl/image_invert_engine_if.sv - start/finish handshake plus dual-port image memory ports A (read) and B (write)
interface image_invert_engine_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  finish;
  logic                  en_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [31:0]           data_r_a;
  logic                  en_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [31:0]           data_w_b;

  modport master (
    input  start, data_r_a,
    output finish, en_a, we_a, addr_a, en_b, we_b, addr_b, data_w_b
  );

  modport slave (
    output start, data_r_a,
    input  finish, en_a, we_a, addr_a, en_b, we_b, addr_b, data_w_b
  );
endinterface

// File: rtl/image_invert_engine.sv
// rtl/image_invert_engine.sv - one-word-per-cycle pixel inverter copying source region to DST_OFFSET
// Read i is issued in cycle i; memory returns it a cycle later, when it is inverted and written.
module image_invert_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int IMG_WORDS  = 25344,
  parameter int DST_OFFSET = 25344
) (
  input logic clk,
  input logic rst,
  image_invert_engine_if.master bus
);
  localparam longint MEM_WORDS = longint'(1) << ADDR_WIDTH;

  if (IMG_WORDS < 1 || DST_OFFSET < IMG_WORDS ||
      longint'(DST_OFFSET) + longint'(IMG_WORDS) > MEM_WORDS) begin : g_bad_cfg
    $error("image_invert_engine: illegal ADDR_WIDTH/IMG_WORDS/DST_OFFSET combination");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_A    = ADDR_WIDTH'(IMG_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] DST_OFF_A = ADDR_WIDTH'(DST_OFFSET);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_pending_q, wr_pending_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_pending_q <= wr_pending_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_pending_d = wr_pending_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          rd_addr_d = '0;
        end
      end
      S_RUN: begin
        wr_pending_d = 1'b1;
        wr_addr_d    = rd_addr_q + DST_OFF_A;
        rd_addr_d    = rd_addr_q + ADDR_WIDTH'(1);
        if (rd_addr_q == LAST_A) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        wr_pending_d = 1'b0;
        state_d      = S_DONE;
      end
      S_DONE: begin
        // A new pass needs start to fall first, so a held start cannot retrigger.
        if (!bus.start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.en_a     = (state_q == S_RUN);
    bus.we_a     = 1'b0;
    bus.addr_a   = (state_q == S_RUN) ? rd_addr_q : '0;
    bus.en_b     = wr_pending_q;
    bus.we_b     = wr_pending_q;
    bus.addr_b   = wr_pending_q ? wr_addr_q : '0;
    // Bytewise 255-p is a plain bitwise NOT: no borrows cross byte lanes.
    bus.data_w_b = wr_pending_q ? ~bus.data_r_a : 32'h0;
    bus.finish   = (state_q == S_DONE);
  end
endmodule
